// File: rtl/nes_controller_device.sv
// Controller-side NES pad link: a 4021-style parallel-in/serial-out shifter
// driven by the host's latch and clock pins, after synchronization into clk.
module nes_controller_device #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_buttons,
   input  logic       i_controller_latch,
   input  logic       i_controller_clock,
   output logic       o_controller_data,
   output logic       o_latched,
   output logic       o_frame_active,
   output logic [3:0] o_bit_index
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, EXHAUSTED} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] latch_sync, clock_sync;
   logic                   latch_d, clock_d;
   logic                   latch_s, clock_s, latch_fall, clock_rise;
   logic [7:0]             shreg, shreg_n;
   logic                   data_n, latched_n, active_n;
   logic [3:0]             idx_n;

   // Synchronizer chains plus one history flop each; clock line idles high
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         latch_sync <= '0;
         clock_sync <= '1;
         latch_d    <= 1'b0;
         clock_d    <= 1'b1;
      end else begin
         latch_sync <= {latch_sync[SYNC_STAGES-2:0], i_controller_latch};
         clock_sync <= {clock_sync[SYNC_STAGES-2:0], i_controller_clock};
         latch_d    <= latch_sync[SYNC_STAGES-1];
         clock_d    <= clock_sync[SYNC_STAGES-1];
      end
   end

   assign latch_s    = latch_sync[SYNC_STAGES-1];
   assign clock_s    = clock_sync[SYNC_STAGES-1];
   assign latch_fall = latch_d & ~latch_s;
   assign clock_rise = clock_s & ~clock_d;

   // Next-state and datapath; a high latch overrides everything, including
   // a clock edge arriving in the same cycle
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      data_n    = o_controller_data;
      idx_n     = o_bit_index;
      active_n  = o_frame_active;
      latched_n = 1'b0;
      if (latch_s) begin
         // transparent parallel load, like the 4021 with P/S high
         state_n  = LOAD;
         shreg_n  = i_buttons;
         data_n   = ~i_buttons[7];
         idx_n    = 4'd0;
         active_n = 1'b0;
      end else begin
         case (state)
            IDLE: data_n = 1'b1;
            LOAD: begin
               // snapshot is whatever the last load cycle captured
               if (latch_fall) begin
                  state_n   = SHIFT;
                  latched_n = 1'b1;
                  active_n  = 1'b1;
                  data_n    = ~shreg[7];
               end
            end
            SHIFT: begin
               if (clock_rise) begin
                  shreg_n = {shreg[6:0], 1'b0};
                  idx_n   = o_bit_index + 4'd1;
                  data_n  = ~shreg[6];
                  if (o_bit_index == 4'd7) begin
                     state_n  = EXHAUSTED;
                     active_n = 1'b0;
                     data_n   = 1'b1;
                  end
               end
            end
            EXHAUSTED: begin
               data_n = 1'b1;
               idx_n  = 4'd8;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state             <= IDLE;
         shreg             <= 8'h00;
         o_controller_data <= 1'b1;
         o_latched         <= 1'b0;
         o_frame_active    <= 1'b0;
         o_bit_index       <= 4'd0;
      end else begin
         state             <= state_n;
         shreg             <= shreg_n;
         o_controller_data <= data_n;
         o_latched         <= latched_n;
         o_frame_active    <= active_n;
         o_bit_index       <= idx_n;
      end
   end

endmodule

// File: tb/tb_nes_controller_device.sv
// Scoreboard bench: host-side driver pushes expected line state, a monitor
// pops and compares at each host sample point.
module tb_nes_controller_device;

   logic       clk = 1'b0;
   logic       rst_n, latch, ck;
   logic [7:0] btn;
   logic       data, latched, active;
   logic [3:0] idx;

   nes_controller_device #(.SYNC_STAGES(2)) dut (
      .clk               (clk),
      .i_rst_n           (rst_n),
      .i_buttons         (btn),
      .i_controller_latch(latch),
      .i_controller_clock(ck),
      .o_controller_data (data),
      .o_latched         (latched),
      .o_frame_active    (active),
      .o_bit_index       (idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       d;
      logic [3:0] i;
      logic       a;
      int         lc;
   } exp_t;

   exp_t q[$];
   event smp;
   bit   fin = 1'b0;
   int   lcnt = 0;
   int   exp_lc = 0;
   int   total = 0, bad = 0;

   // count latch pulses seen on the DUT
   always @(posedge clk) if (latched) lcnt <= lcnt + 1;

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not end");
      $fatal(1);
   end

   // monitor: pop expected on each sample strobe and compare
   initial begin
      exp_t e;
      forever begin
         @(smp);
         if (fin) begin
            total++;
            if (q.size() != 0) begin
               bad++;
               $display("FAIL leftover: got=%0d entries want=0", q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end else if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL underflow: sample with no expected entry");
         end else begin
            e = q.pop_front();
            total += 4;
            if (data !== e.d) begin bad++; $display("FAIL %s data: got=%b want=%b", e.name, data, e.d); end
            if (idx !== e.i) begin bad++; $display("FAIL %s idx: got=%0d want=%0d", e.name, idx, e.i); end
            if (active !== e.a) begin bad++; $display("FAIL %s active: got=%b want=%b", e.name, active, e.a); end
            if (lcnt != e.lc) begin bad++; $display("FAIL %s latched_cnt: got=%0d want=%0d", e.name, lcnt, e.lc); end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm, input logic d, input logic [3:0] i, input logic a);
      exp_t e;
      e.name = nm; e.d = d; e.i = i; e.a = a; e.lc = exp_lc;
      q.push_back(e);
      -> smp;
   endtask

   task automatic sample(input string nm, input logic d, input logic [3:0] i, input logic a);
      @(negedge clk);
      push(nm, d, i, a);
   endtask

   // latch pulse: b_first at rise, b_last for the tail, b_after once frozen
   task automatic latch_pulse(input logic [7:0] b_first, input logic [7:0] b_last,
                              input logic [7:0] b_after, input string nm);
      btn = b_first; latch = 1'b1;
      cyc(3);
      sample({nm, "_load"}, ~b_first[7], 4'd0, 1'b0);
      btn = b_last;
      cyc(3);
      latch = 1'b0;
      cyc(4);
      btn = b_after;
      exp_lc++;
      cyc(1);
      sample({nm, "_bit0"}, ~b_last[7], 4'd0, 1'b1);
   endtask

   task automatic clk_pulse(input string nm, input logic d, input logic [3:0] i, input logic a);
      ck = 1'b0;
      cyc(6);
      ck = 1'b1;
      cyc(5);
      sample(nm, d, i, a);
   endtask

   // model: bit k of frame b after k rising edges
   task automatic clocks(input logic [7:0] b, input int from, input int to, input string nm);
      for (int k = from; k <= to; k++) begin
         if (k < 8) clk_pulse(nm, ~b[7-k], 4'(k), 1'b1);
         else       clk_pulse(nm, 1'b1, 4'd8, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; latch = 1'b0; ck = 1'b1; btn = 8'h00;
      cyc(2);
      push("reset", 1'b1, 4'd0, 1'b0);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);

      // basic frame, A and Right pressed, 7 clocks
      latch_pulse(8'h81, 8'h81, 8'h81, "f81");
      clocks(8'h81, 1, 7, "f81_clk");

      // buttons change during latch and after freeze
      latch_pulse(8'h00, 8'h10, 8'hFF, "f10");
      clocks(8'h10, 1, 7, "f10_clk");

      // run past the end: exhaustion and saturation
      latch_pulse(8'hFF, 8'hFF, 8'hFF, "fFF");
      clocks(8'hFF, 1, 10, "fFF_clk");

      // re-latch mid-frame aborts
      latch_pulse(8'h55, 8'h55, 8'h55, "f55");
      clocks(8'h55, 1, 3, "f55_clk");
      latch_pulse(8'hAA, 8'hAA, 8'hAA, "fAA");
      clocks(8'hAA, 1, 7, "fAA_clk");

      // asynchronous reset mid-shift
      latch_pulse(8'h3C, 8'h3C, 8'h3C, "f3C");
      clocks(8'h3C, 1, 2, "f3C_clk");
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      push("rst_async", 1'b1, 4'd0, 1'b0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      clk_pulse("post_rst0", 1'b1, 4'd0, 1'b0);
      clk_pulse("post_rst1", 1'b1, 4'd0, 1'b0);

      // latch and clock rise together while shifting: latch wins
      latch_pulse(8'h40, 8'h40, 8'h40, "f40");
      clocks(8'h40, 1, 1, "f40_clk");
      btn = 8'hC3; ck = 1'b0;
      cyc(6);
      latch = 1'b1; ck = 1'b1;
      cyc(3);
      sample("same_load", 1'b0, 4'd0, 1'b0);
      cyc(3);
      latch = 1'b0;
      cyc(4);
      exp_lc++;
      cyc(1);
      sample("same_bit0", 1'b0, 4'd0, 1'b1);
      clocks(8'hC3, 1, 2, "same_clk");

      cyc(2);
      fin = 1'b1;
      -> smp;
   end

endmodule
